// File: rtl/inst_sequencer.sv
// ---------------------------------------------------------------------------
// inst_sequencer
//   Drives the core's 20-bit instruction bus and its mem_in row port. It
//   replaces bench-driven control. On start it first streams total_cycle Q
//   rows and then col K rows from a valid/ready source into qmem/kmem. It
//   then plays out the fixed schedule:
//     K load -> execute -> ofifo->pmem -> SFP accumulate -> SFP divide/writeback
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high; aborts any job in progress
//   start     job request, sampled only in IDLE
//   in_valid  in_data holds a Q/K row
//   in_ready  a row is accepted this cycle (combinational from state)
//   in_data   row, element j at [j*bw +: bw]
//   mem_in    registered row presented to the core
//   inst      registered instruction word:
//               [19]wr2pmem [18]div [17]acc [16]ofifo_rd
//               [15:12]qkmem_add [11:8]pmem_add [7]execute [6]load
//               [5]qmem_rd [4]qmem_wr [3]kmem_rd [2]kmem_wr [1]pmem_rd [0]pmem_wr
//   busy      high in every state except IDLE
//   done      high for the single cycle spent in DONE
//   phase     current state encoding, for debug
//
// Handshake: a row transfers on a rising edge where in_valid && in_ready are
// both high. in_ready is high only in Q_WR/K_WR. in_valid is ignored in
// every other state. The source may hold or drop in_valid at any time.
// ---------------------------------------------------------------------------
module inst_sequencer #(
  parameter int total_cycle = 8,
  parameter int col         = 8,
  parameter int pr          = 8,
  parameter int bw          = 8,
  parameter int gap_cyc     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [pr*bw-1:0] in_data,
  output logic [pr*bw-1:0] mem_in,
  output logic [19:0]      inst,
  output logic             busy,
  output logic             done,
  output logic [3:0]       phase
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_Q_WR  = 4'd1,
    S_K_WR  = 4'd2,
    S_LOAD  = 4'd3,
    S_GAP1  = 4'd4,
    S_EXEC  = 4'd5,
    S_GAP2  = 4'd6,
    S_OFIFO = 4'd7,
    S_ACC   = 4'd8,
    S_DIV   = 4'd9,
    S_DONE  = 4'd10
  } state_t;

  localparam int B_WR2PMEM  = 19;
  localparam int B_DIV      = 18;
  localparam int B_ACC      = 17;
  localparam int B_OFIFO_RD = 16;
  localparam int B_EXECUTE  = 7;
  localparam int B_LOAD     = 6;
  localparam int B_QMEM_RD  = 5;
  localparam int B_QMEM_WR  = 4;
  localparam int B_KMEM_RD  = 3;
  localparam int B_KMEM_WR  = 2;
  localparam int B_PMEM_RD  = 1;
  localparam int B_PMEM_WR  = 0;

  localparam logic [7:0] TC       = 8'(total_cycle);
  localparam logic [7:0] TC2      = 8'(2 * total_cycle);
  localparam logic [7:0] COLS     = 8'(col);
  localparam logic [7:0] GAP_LAST = 8'(gap_cyc - 1);
  // DIV: 1 divide cycle, 3 read cycles, then total_cycle+1 slots of 4 cycles.
  localparam logic [7:0] DIV_LAST = 8'(4 * total_cycle + 7);

  state_t     state;
  logic [7:0] cnt;

  // Derived counter views: LOAD reads address c-1; DIV slots start at c=4.
  logic [3:0] cnt_m1;
  logic [5:0] div_rel;
  logic [3:0] div_k;
  logic [3:0] div_k1;

  assign cnt_m1  = 4'(cnt - 8'd1);
  assign div_rel = 6'(cnt - 8'd4);
  assign div_k   = div_rel[5:2];
  assign div_k1  = div_k + 4'd1;

  assign in_ready = (state == S_Q_WR) || (state == S_K_WR);
  assign busy     = (state != S_IDLE);
  assign phase    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      inst   <= '0;
      mem_in <= '0;
      done   <= 1'b0;
    end else begin
      // Every cycle not explicitly driving a field issues a zero instruction.
      inst <= '0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_Q_WR;
            cnt   <= '0;
          end
        end

        S_Q_WR, S_K_WR: begin
          if (in_valid) begin
            mem_in          <= in_data;
            inst[15:12]     <= cnt[3:0];
            if (state == S_Q_WR) begin
              inst[B_QMEM_WR] <= 1'b1;
              if (cnt == TC - 8'd1) begin
                cnt   <= '0;
                state <= S_K_WR;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end else begin
              inst[B_KMEM_WR] <= 1'b1;
              if (cnt == COLS - 8'd1) begin
                cnt   <= '0;
                state <= S_LOAD;
              end else begin
                cnt <= cnt + 8'd1;
              end
            end
          end
        end

        S_LOAD: begin
          // load stays up one cycle past the last kmem read so the final
          // K row reaches the array before load drops.
          if (cnt <= COLS + 8'd1) inst[B_LOAD] <= 1'b1;
          if (cnt >= 8'd1 && cnt <= COLS) begin
            inst[B_KMEM_RD] <= 1'b1;
            inst[15:12]     <= cnt_m1;
          end
          if (cnt == COLS + 8'd2) begin
            cnt   <= '0;
            state <= S_GAP1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_GAP1, S_GAP2: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= (state == S_GAP1) ? S_EXEC : S_OFIFO;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_EXEC: begin
          if (cnt < TC) begin
            inst[B_EXECUTE] <= 1'b1;
            inst[B_QMEM_RD] <= 1'b1;
            inst[15:12]     <= cnt[3:0];
          end
          if (cnt == TC) begin
            cnt   <= '0;
            state <= S_GAP2;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_OFIFO: begin
          if (cnt < TC) begin
            inst[B_OFIFO_RD] <= 1'b1;
            inst[B_PMEM_WR]  <= 1'b1;
            inst[11:8]       <= cnt[3:0];
          end
          if (cnt == TC) begin
            cnt   <= '0;
            state <= S_ACC;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_ACC: begin
          // Each pmem row is read twice: the SFP accumulator needs two beats.
          if (cnt < TC2) begin
            inst[B_PMEM_RD] <= 1'b1;
            inst[B_ACC]     <= 1'b1;
            inst[11:8]      <= cnt[4:1];
          end
          if (cnt == TC2) begin
            cnt   <= '0;
            state <= S_DIV;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_DIV: begin
          if (cnt == 8'd0) begin
            inst[B_DIV] <= 1'b1;
          end else if (cnt <= 8'd3) begin
            inst[B_PMEM_RD] <= 1'b1;
          end else begin
            // Slot k: write row k back while already reading row k+1, so
            // normalized rows end up shifted to pmem 1..total_cycle.
            inst[B_PMEM_RD]  <= 1'b1;
            inst[B_WR2PMEM]  <= 1'b1;
            case (div_rel[1:0])
              2'd0: begin
                inst[B_DIV]     <= 1'b1;
                inst[B_PMEM_WR] <= 1'b1;
                inst[11:8]      <= div_k;
              end
              2'd1: begin
                inst[B_DIV] <= 1'b1;
                inst[11:8]  <= div_k1;
              end
              default: inst[11:8] <= div_k1;
            endcase
          end
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_inst_sequencer
//   Lock-step bench for inst_sequencer. Each driven cycle pushes the expected
//   post-edge view {in_ready, phase, busy, done, inst} plus the expected
//   mem_in onto scoreboard queues. tick() then pops and compares both, 1 ns
//   after the rising edge. The expected schedule is written out segment by
//   segment from the job description.
// ---------------------------------------------------------------------------
module tb_inst_sequencer;

  localparam int TC  = 8;
  localparam int COL = 8;
  localparam int PR  = 8;
  localparam int BW  = 8;
  localparam int GAP = 10;
  localparam int DW  = PR * BW;
  localparam int EW  = 27;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] mem_in;
  logic [19:0]   inst;
  logic          busy;
  logic          done;
  logic [3:0]    phase;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] mem_q[$];
  logic [DW-1:0] cur_mem;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    n_tick = 0;
  string tag    = "init";

  always #5 clk = ~clk;

  inst_sequencer #(
    .total_cycle(TC),
    .col        (COL),
    .pr         (PR),
    .bw         (BW),
    .gap_cyc    (GAP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .mem_in  (mem_in),
    .inst    (inst),
    .busy    (busy),
    .done    (done),
    .phase   (phase)
  );

  function automatic logic [DW-1:0] rand_row();
    return {$urandom(), $urandom()};
  endfunction

  // Expected view after the next edge, given the phase the DUT should land in.
  task automatic push(input logic [3:0] ph, input logic [19:0] ins);
    exp_q.push_back({(ph == 4'd1 || ph == 4'd2), ph, (ph != 4'd0), (ph == 4'd10), ins});
    mem_q.push_back(cur_mem);
  endtask

  task automatic tick();
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    logic [DW-1:0] m;
    @(posedge clk);
    #1;
    n_tick++;
    e = exp_q.pop_front();
    m = mem_q.pop_front();
    o = {in_ready, phase, busy, done, inst};
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s tick %0d: {rdy,phase,busy,done,inst} observed %h expected %h", tag, n_tick, o, e);
    end
    n_chk++;
    assert (mem_in === m) else begin
      n_fail++;
      $error("FAIL %s_mem tick %0d: mem_in observed %h expected %h", tag, n_tick, mem_in, m);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    exp_q.delete();
    mem_q.delete();
    cur_mem = '0;
    repeat (n) begin
      push(4'd0, 20'd0);
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic start_job();
    start = 1'b1;
    push(4'd1, 20'd0);
    tick();
    start = 1'b0;
  endtask

  // mode 0: in_valid every cycle; mode 1: random stalls before each row.
  task automatic load_q(input int mode);
    logic [19:0] ins;
    for (int i = 0; i < TC; i++) begin
      if (mode == 1) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = rand_row();
          push(4'd1, 20'd0);
          tick();
        end
      end
      in_valid    = 1'b1;
      in_data     = rand_row();
      cur_mem     = in_data;
      ins         = '0;
      ins[4]      = 1'b1;
      ins[15:12]  = 4'(i);
      push((i == TC - 1) ? 4'd2 : 4'd1, ins);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // mode 0: in_valid toggles 1,0,1,0,...; mode 1: random stalls.
  task automatic load_k(input int mode);
    logic [19:0] ins;
    int          n_idle;
    for (int j = 0; j < COL; j++) begin
      n_idle = (mode == 0) ? ((j > 0) ? 1 : 0) : int'($urandom_range(0, 2));
      repeat (n_idle) begin
        in_valid = 1'b0;
        in_data  = rand_row();
        push(4'd2, 20'd0);
        tick();
      end
      in_valid   = 1'b1;
      in_data    = rand_row();
      cur_mem    = in_data;
      ins        = '0;
      ins[2]     = 1'b1;
      ins[15:12] = 4'(j);
      push((j == COL - 1) ? 4'd3 : 4'd2, ins);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Expected stream from the first LOAD decision through DONE.
  task automatic push_schedule();
    logic [19:0] ins;
    for (int c = 0; c <= COL + 2; c++) begin
      ins = '0;
      if (c <= COL + 1) ins[6] = 1'b1;
      if (c >= 1 && c <= COL) begin
        ins[3]     = 1'b1;
        ins[15:12] = 4'(c - 1);
      end
      push((c == COL + 2) ? 4'd4 : 4'd3, ins);
    end
    for (int g = 0; g < GAP; g++) push((g == GAP - 1) ? 4'd5 : 4'd4, 20'd0);
    for (int c = 0; c <= TC; c++) begin
      ins = '0;
      if (c < TC) begin
        ins[7]     = 1'b1;
        ins[5]     = 1'b1;
        ins[15:12] = 4'(c);
      end
      push((c == TC) ? 4'd6 : 4'd5, ins);
    end
    for (int g = 0; g < GAP; g++) push((g == GAP - 1) ? 4'd7 : 4'd6, 20'd0);
    for (int c = 0; c <= TC; c++) begin
      ins = '0;
      if (c < TC) begin
        ins[16]   = 1'b1;
        ins[0]    = 1'b1;
        ins[11:8] = 4'(c);
      end
      push((c == TC) ? 4'd8 : 4'd7, ins);
    end
    // ACC: pmem_add 0,0,1,1,...,7,7
    for (int c = 0; c <= 2 * TC; c++) begin
      ins = '0;
      if (c < 2 * TC) begin
        ins[1]    = 1'b1;
        ins[17]   = 1'b1;
        ins[11:8] = 4'(c / 2);
      end
      push((c == 2 * TC) ? 4'd9 : 4'd8, ins);
    end
    ins     = '0;
    ins[18] = 1'b1;
    push(4'd9, ins);
    ins = '0;
    ins[1] = 1'b1;
    repeat (3) push(4'd9, ins);
    // DIV slots: pmem_wr at addresses 0..TC, one per slot.
    for (int k = 0; k <= TC; k++) begin
      for (int s = 0; s < 4; s++) begin
        ins     = '0;
        ins[1]  = 1'b1;
        ins[19] = 1'b1;
        if (s == 0) begin
          ins[18]   = 1'b1;
          ins[0]    = 1'b1;
          ins[11:8] = 4'(k);
        end else begin
          if (s == 1) ins[18] = 1'b1;
          ins[11:8] = 4'(k + 1);
        end
        push((k == TC && s == 3) ? 4'd10 : 4'd9, ins);
      end
    end
    push(4'd0, 20'd0);
  endtask

  // First LOAD cycle is driven with in_valid and start high: both must be ignored.
  task automatic begin_schedule();
    push_schedule();
    in_valid = 1'b1;
    in_data  = rand_row();
    start    = 1'b1;
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() != 0) tick();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    cur_mem  = '0;

    tag = "reset";
    do_reset(3);

    tag = "idle";
    in_valid = 1'b1;
    in_data  = rand_row();
    push(4'd0, 20'd0);
    tick();
    in_valid = 1'b0;

    tag = "job1_start";
    start_job();
    tag = "job1_q";
    load_q(0);
    tag = "job1_k";
    load_k(0);
    tag = "job1_sched";
    begin_schedule();
    drain();

    tag = "job2_start";
    start_job();
    tag = "job2_q";
    load_q(1);
    tag = "job2_k";
    load_k(1);
    tag = "job2_sched";
    begin_schedule();
    // 11 LOAD + 10 GAP1 decisions, then 3 EXEC decisions.
    repeat (23) tick();

    tag = "abort_reset";
    do_reset(3);
    tag = "abort_idle";
    push(4'd0, 20'd0);
    tick();

    tag = "job3_start";
    start_job();
    tag = "job3_q";
    load_q(1);
    tag = "job3_k";
    load_k(1);
    tag = "job3_sched";
    begin_schedule();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
